// File: rtl/keccak_sponge.sv
// Sponge controller around an external keccak-f[1600] block: absorb, SHA-3 pad, permute, digest.
// Optional squeeze-more output (XOF) enabled by defining KECCAK_SPONGE_XOF_EN.
module keccak_sponge #(
  parameter int unsigned RATE_BITS = 1088,
  parameter int unsigned OUT_BITS  = 256,
  parameter logic [7:0]  DSBYTE    = 8'h06
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [63:0]         i_data,
  input  logic [3:0]          i_nbytes,
  input  logic                i_last,
  input  logic                i_valid,
  output logic                o_ready,
  output logic [OUT_BITS-1:0] o_digest,
  output logic                o_digest_valid,
  input  logic                i_digest_ready,
`ifdef KECCAK_SPONGE_XOF_EN
  input  logic                i_more,
`endif
  output logic [1599:0]       o_perm_sponge,
  output logic                o_perm_trigger,
  input  logic [1599:0]       i_perm_sponge,
  input  logic                i_perm_ready
);

  localparam int unsigned RATE_WORDS  = RATE_BITS / 64;
  localparam int unsigned RATE_BYTES  = RATE_BITS / 8;
  localparam int unsigned PAD_END_BIT = 8 * (RATE_BYTES - 1);
  localparam logic [4:0]  LAST_LANE   = 5'(RATE_WORDS - 1);
  localparam logic [7:0]  RATE_BYTES8 = 8'(RATE_BYTES);

  typedef enum logic [2:0] {
    StIdle,
    StAbsorb,
    StPad,
    StPermStart,
    StPermWaitLo,
    StPermWaitHi,
    StPermSettle,
    StDone
  } state_e;

  state_e         r_fsm, w_fsm_nxt;
  state_e         r_ret, w_ret_nxt;
  logic [1599:0]  r_state, w_state_nxt;
  logic [4:0]     r_lane, w_lane_nxt;
  logic [7:0]     r_pos, w_pos_nxt;

  logic [3:0]     w_nbytes;
  logic [63:0]    w_mask;
  logic [10:0]    w_lane_base;
  logic [10:0]    w_pos_base;

  // Only the final word is byte-masked; counts above 8 saturate to a full word.
  assign w_nbytes    = (i_nbytes > 4'd8) ? 4'd8 : i_nbytes;
  assign w_mask      = i_last ? ~({64{1'b1}} << {w_nbytes, 3'b000}) : {64{1'b1}};
  assign w_lane_base = {r_lane, 6'd0};
  assign w_pos_base  = {r_pos, 3'd0};

  assign o_perm_sponge = r_state;
  assign o_digest      = r_state[OUT_BITS-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fsm   <= StIdle;
      r_ret   <= StIdle;
      r_state <= '0;
      r_lane  <= '0;
      r_pos   <= '0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_ret   <= w_ret_nxt;
      r_state <= w_state_nxt;
      r_lane  <= w_lane_nxt;
      r_pos   <= w_pos_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt      = r_fsm;
    w_ret_nxt      = r_ret;
    w_state_nxt    = r_state;
    w_lane_nxt     = r_lane;
    w_pos_nxt      = r_pos;
    o_ready        = 1'b0;
    o_digest_valid = 1'b0;
    o_perm_trigger = 1'b0;

    case (r_fsm)
      StIdle: begin
        w_state_nxt = '0;
        w_lane_nxt  = '0;
        w_pos_nxt   = '0;
        w_fsm_nxt   = StAbsorb;
      end

      StAbsorb: begin
        o_ready = 1'b1;
        if (i_valid) begin
          w_state_nxt[w_lane_base +: 64] = r_state[w_lane_base +: 64] ^ (i_data & w_mask);
          if (i_last) begin
            w_pos_nxt = {r_lane, 3'b000} + {4'd0, w_nbytes};
            w_fsm_nxt = StPad;
          end else if (r_lane == LAST_LANE) begin
            w_lane_nxt = '0;
            w_ret_nxt  = StAbsorb;
            w_fsm_nxt  = StPermStart;
          end else begin
            w_lane_nxt = r_lane + 5'd1;
          end
        end
      end

      StPad: begin
        // A message ending exactly on a block boundary needs one more block for the padding.
        if (r_pos == RATE_BYTES8) begin
          w_pos_nxt = '0;
          w_ret_nxt = StPad;
        end else begin
          w_state_nxt[w_pos_base +: 8]   = w_state_nxt[w_pos_base +: 8] ^ DSBYTE;
          w_state_nxt[PAD_END_BIT +: 8]  = w_state_nxt[PAD_END_BIT +: 8] ^ 8'h80;
          w_ret_nxt = StDone;
        end
        w_fsm_nxt = StPermStart;
      end

      StPermStart: begin
        if (i_perm_ready) begin
          o_perm_trigger = 1'b1;
          w_fsm_nxt      = StPermWaitLo;
        end
      end

      StPermWaitLo: begin
        if (!i_perm_ready) w_fsm_nxt = StPermWaitHi;
      end

      StPermWaitHi: begin
        if (i_perm_ready) w_fsm_nxt = StPermSettle;
      end

      StPermSettle: begin
        w_state_nxt = i_perm_sponge;
        w_fsm_nxt   = r_ret;
      end

      StDone: begin
        o_digest_valid = 1'b1;
        if (i_digest_ready) begin
          w_fsm_nxt = StIdle;
`ifdef KECCAK_SPONGE_XOF_EN
          if (i_more) begin
            w_ret_nxt = StDone;
            w_fsm_nxt = StPermStart;
          end
`endif
        end
      end

      default: w_fsm_nxt = StIdle;
    endcase
  end

endmodule
